mmu_mem_arbiter: RTL and testbench

- Sits directly downstream of the MMU page walker. It owns the single DRAM request port shared by PTE traffic (L1/L0 reads, A/D write-back) and the CPU's translated (physical) load/store/fetch.
- Serialises both sources into one DRAM transaction at a time and returns read data. Produces the busy flag and held read data that the walker and CPU poll.
- Holds one pending slot per source, gives PTE traffic fixed priority, and has a watchdog timeout.

---
 rtl/mmu_mem_arbiter_pkg.sv | 23 ++
 rtl/mmu_mem_arbiter_if.sv | 46 ++++
 rtl/mmu_mem_req_slot.sv | 32 +++
 rtl/mmu_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mmu_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_mem_arbiter_pkg.sv
// Shared definitions for the MMU memory arbiter: FSM encoding, source select and
// the access/PTE constants used by the walker side of the MMU.
package mmu_mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CMD    = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic SRC_PTE = 1'b0;
    localparam logic SRC_CPU = 1'b1;

    localparam logic [1:0] ACCESS_LOAD  = 2'd0;
    localparam logic [1:0] ACCESS_STORE = 2'd1;
    localparam logic [1:0] ACCESS_FETCH = 2'd2;

    localparam int PTE_V_BIT = 0;
    localparam int PTE_A_BIT = 6;
    localparam int PTE_D_BIT = 7;

    localparam int TMO_CNT_W = 10;

endpackage

// File: rtl/mmu_mem_arbiter_if.sv
// Request/DRAM/status bundle between the MMU-side clients and the memory arbiter.
interface mmu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              pte_req;
    logic              pte_we;
    logic [ADDR_W-1:0] pte_addr;
    logic [DATA_W-1:0] pte_wdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [MASK_W-1:0] cpu_wmask;
    logic              dram_req;
    logic              dram_ack;
    logic              dram_we;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic [MASK_W-1:0] dram_wmask;
    logic              dram_rvalid;
    logic [DATA_W-1:0] dram_rdata;
    logic              busy;
    logic [DATA_W-1:0] odata;
    logic              done_pte;
    logic              done_cpu;
    logic              err;

    modport slave (
        input  pte_req, pte_we, pte_addr, pte_wdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
        input  dram_ack, dram_rvalid, dram_rdata,
        output dram_req, dram_we, dram_addr, dram_wdata, dram_wmask,
        output busy, odata, done_pte, done_cpu, err
    );

    modport master (
        output pte_req, pte_we, pte_addr, pte_wdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
        output dram_ack, dram_rvalid, dram_rdata,
        input  dram_req, dram_we, dram_addr, dram_wdata, dram_wmask,
        input  busy, odata, done_pte, done_cpu, err
    );
endinterface

// File: rtl/mmu_mem_req_slot.sv
// Single-entry request holder. A set while already full is reported on ovf and dropped.
module mmu_mem_req_slot
    import mmu_mem_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         pend,
    output logic [W-1:0] dout,
    output logic         ovf
);

    assign ovf = set & pend;

    // Slot occupancy and payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            dout <= '0;
        end else if (set && !pend) begin
            pend <= 1'b1;
            dout <= din;
        end else if (clr) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/mmu_mem_arbiter.sv
// Serialises PTE and CPU physical accesses onto one DRAM port, PTE first,
// with a wait watchdog and held read data.
module mmu_mem_arbiter
    import mmu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    mmu_mem_arbiter_if.slave   bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int SLOT_W = 1 + ADDR_W + DATA_W + MASK_W;
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

    logic [1:0]            state_r, state_nxt;
    logic [TMO_CNT_W-1:0]  cnt_r;
    logic                  src_r;
    logic                  cmd_we_r;
    logic [ADDR_W-1:0]     cmd_addr_r;
    logic [DATA_W-1:0]     cmd_wdata_r;
    logic [MASK_W-1:0]     cmd_wmask_r;
    logic                  dram_req_r, done_pte_r, done_cpu_r, err_r;
    logic [DATA_W-1:0]     odata_r;

    logic                  sel_pte, sel_cpu, timeout_hit, go_done;
    logic                  pte_pend, cpu_pend, pte_ovf, cpu_ovf;
    logic [SLOT_W-1:0]     pte_din, cpu_din, pte_dout, cpu_dout, sel_word;

    assign pte_din = {bus.pte_we, bus.pte_addr, bus.pte_wdata, {MASK_W{1'b1}}};
    assign cpu_din = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, bus.cpu_wmask};

    // A strobe taken straight from IDLE bypasses its slot, so it must not also be latched.
    mmu_mem_req_slot #(.W(SLOT_W)) u_pte_slot (
        .clk (clk), .rst (rst),
        .set (bus.pte_req & ~(sel_pte & ~pte_pend)),
        .clr (sel_pte & pte_pend),
        .din (pte_din), .pend (pte_pend), .dout (pte_dout), .ovf (pte_ovf)
    );

    mmu_mem_req_slot #(.W(SLOT_W)) u_cpu_slot (
        .clk (clk), .rst (rst),
        .set (bus.cpu_req & ~(sel_cpu & ~cpu_pend)),
        .clr (sel_cpu & cpu_pend),
        .din (cpu_din), .pend (cpu_pend), .dout (cpu_dout), .ovf (cpu_ovf)
    );

    // Next-state, source selection and watchdog decision.
    always_comb begin
        state_nxt   = state_r;
        sel_pte     = 1'b0;
        sel_cpu     = 1'b0;
        timeout_hit = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pte_pend || bus.pte_req) begin
                    sel_pte   = 1'b1;
                    state_nxt = ST_CMD;
                end else if (cpu_pend || bus.cpu_req) begin
                    sel_cpu   = 1'b1;
                    state_nxt = ST_CMD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (bus.dram_ack) begin
                    state_nxt = cmd_we_r ? ST_DONE : ST_RDWAIT;
                end else if (cnt_r == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    state_nxt = ST_CMD;
                end
            end
            ST_RDWAIT: begin
                if (bus.dram_rvalid) begin
                    state_nxt = ST_DONE;
                end else if (cnt_r == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    state_nxt = ST_RDWAIT;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign go_done  = (state_nxt == ST_DONE) | timeout_hit;
    assign sel_word = sel_pte ? (pte_pend ? pte_dout : pte_din)
                              : (cpu_pend ? cpu_dout : cpu_din);

    // State, watchdog counter, command registers and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            src_r       <= SRC_PTE;
            cmd_we_r    <= 1'b0;
            cmd_addr_r  <= '0;
            cmd_wdata_r <= '0;
            cmd_wmask_r <= '0;
            dram_req_r  <= 1'b0;
            done_pte_r  <= 1'b0;
            done_cpu_r  <= 1'b0;
            err_r       <= 1'b0;
            odata_r     <= '0;
        end else begin
            state_r    <= state_nxt;
            dram_req_r <= (state_nxt == ST_CMD);
            done_pte_r <= go_done & (src_r == SRC_PTE);
            done_cpu_r <= go_done & (src_r == SRC_CPU);
            err_r      <= err_r | pte_ovf | cpu_ovf | timeout_hit;
            if (state_nxt != state_r) begin
                cnt_r <= '0;
            end else if (state_r == ST_CMD || state_r == ST_RDWAIT) begin
                cnt_r <= cnt_r + {{(TMO_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= '0;
            end
            if (sel_pte || sel_cpu) begin
                src_r <= sel_cpu ? SRC_CPU : SRC_PTE;
                {cmd_we_r, cmd_addr_r, cmd_wdata_r, cmd_wmask_r} <= sel_word;
            end
            if (state_r == ST_RDWAIT && bus.dram_rvalid) begin
                odata_r <= bus.dram_rdata;
            end
        end
    end

    assign bus.dram_req   = dram_req_r;
    assign bus.dram_we    = cmd_we_r;
    assign bus.dram_addr  = cmd_addr_r;
    assign bus.dram_wdata = cmd_wdata_r;
    assign bus.dram_wmask = cmd_wmask_r;
    assign bus.odata      = odata_r;
    assign bus.done_pte   = done_pte_r;
    assign bus.done_cpu   = done_cpu_r;
    assign bus.err        = err_r;
    assign bus.busy       = (state_r != ST_IDLE) | pte_pend | cpu_pend | bus.pte_req | bus.cpu_req;

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// Directed bench for mmu_mem_arbiter: inputs driven 1ns after posedge, outputs checked on negedge.
module tb_mmu_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cmd_cnt  = 0;
    int   c0;

    always #5 clk = ~clk;

    mmu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mmu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Count DRAM commands accepted.
    always @(negedge clk) begin
        if (!rst && bus.dram_req && bus.dram_ack) cmd_cnt <= cmd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Single transaction with immediate ack and rvalid on the cycle after ack.
    task automatic run_txn(input logic is_pte, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input logic [31:0] rdata, input logic [31:0] exp_odata);
        step;
        if (is_pte) begin
            bus.pte_req = 1'b1; bus.pte_we = we; bus.pte_addr = addr; bus.pte_wdata = wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
            bus.cpu_wdata = wdata; bus.cpu_wmask = wmask;
        end
        step;
        bus.pte_req = 1'b0; bus.cpu_req = 1'b0; bus.dram_ack = 1'b1;
        @(negedge clk);
        chk("txn_req", bus.dram_req, 1);
        chk("txn_addr", bus.dram_addr, addr);
        chk("txn_we", bus.dram_we, we);
        chk("txn_wmask", bus.dram_wmask, is_pte ? 4'hF : wmask);
        if (we) chk("txn_wdata", bus.dram_wdata, wdata);
        step;
        bus.dram_ack = 1'b0;
        if (!we) begin
            bus.dram_rvalid = 1'b1; bus.dram_rdata = rdata;
            step;
            bus.dram_rvalid = 1'b0;
        end
        @(negedge clk);
        chk("txn_done", is_pte ? bus.done_pte : bus.done_cpu, 1);
        chk("txn_odata", bus.odata, exp_odata);
        step;
        @(negedge clk);
        chk("txn_idle_busy", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pte_req = 1'b0; bus.pte_we = 1'b0; bus.pte_addr = 32'h0; bus.pte_wdata = 32'h0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.cpu_wmask = 4'h0; bus.dram_ack = 1'b0; bus.dram_rvalid = 1'b0; bus.dram_rdata = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dram_req", bus.dram_req, 0);
        chk("rst_dram_addr", bus.dram_addr, 0);
        chk("rst_dram_wmask", bus.dram_wmask, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_odata", bus.odata, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_done", {bus.done_pte, bus.done_cpu}, 0);
        step;
        rst = 1'b0;

        // PTE read: ack at once, rvalid two cycles after ack
        step;
        bus.pte_req = 1'b1; bus.pte_we = 1'b0; bus.pte_addr = 32'h8000_1004;
        @(negedge clk);
        chk("t1_busy_strobe", bus.busy, 1);
        chk("t1_no_req_yet", bus.dram_req, 0);
        step;
        bus.pte_req = 1'b0; bus.dram_ack = 1'b1;
        @(negedge clk);
        chk("t1_req", bus.dram_req, 1);
        chk("t1_addr", bus.dram_addr, 32'h8000_1004);
        chk("t1_we", bus.dram_we, 0);
        chk("t1_wmask", bus.dram_wmask, 4'hF);
        step;
        bus.dram_ack = 1'b0;
        @(negedge clk);
        chk("t1_rdwait_req", bus.dram_req, 0);
        chk("t1_rdwait_busy", bus.busy, 1);
        step;
        bus.dram_rvalid = 1'b1; bus.dram_rdata = 32'h2000_0C01;
        step;
        bus.dram_rvalid = 1'b0;
        @(negedge clk);
        chk("t1_done_pte", bus.done_pte, 1);
        chk("t1_done_cpu", bus.done_cpu, 0);
        chk("t1_odata", bus.odata, 32'h2000_0C01);
        step;
        @(negedge clk);
        chk("t1_done_drop", bus.done_pte, 0);
        chk("t1_busy_end", bus.busy, 0);
        chk("t1_cmd_cnt", cmd_cnt, 1);

        // Simultaneous PTE write and CPU read: PTE first
        step;
        bus.pte_req = 1'b1; bus.pte_we = 1'b1; bus.pte_addr = 32'h8000_2008; bus.pte_wdata = 32'h1234_00C3;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_4000; bus.cpu_wmask = 4'hF;
        step;
        bus.pte_req = 1'b0; bus.cpu_req = 1'b0; bus.dram_ack = 1'b1;
        @(negedge clk);
        chk("t2_first_addr", bus.dram_addr, 32'h8000_2008);
        chk("t2_first_we", bus.dram_we, 1);
        chk("t2_first_wdata", bus.dram_wdata, 32'h1234_00C3);
        step;
        bus.dram_ack = 1'b0;
        @(negedge clk);
        chk("t2_done_pte", bus.done_pte, 1);
        chk("t2_busy_cpu_pend", bus.busy, 1);
        step;
        @(negedge clk);
        chk("t2_idle_gap_req", bus.dram_req, 0);
        step;
        bus.dram_ack = 1'b1;
        @(negedge clk);
        chk("t2_second_req", bus.dram_req, 1);
        chk("t2_second_addr", bus.dram_addr, 32'h0000_4000);
        chk("t2_second_we", bus.dram_we, 0);
        step;
        bus.dram_ack = 1'b0; bus.dram_rvalid = 1'b1; bus.dram_rdata = 32'hCAFE_F00D;
        step;
        bus.dram_rvalid = 1'b0;
        @(negedge clk);
        chk("t2_done_cpu", bus.done_cpu, 1);
        chk("t2_odata", bus.odata, 32'hCAFE_F00D);
        chk("t2_err", bus.err, 0);
        step;
        @(negedge clk);
        chk("t2_busy_end", bus.busy, 0);

        // CPU masked store keeps odata
        run_txn(1'b0, 1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 4'b0011, 32'h0, 32'hCAFE_F00D);

        // Second PTE strobe while slot full and CPU read in flight is dropped
        step;
        c0 = cmd_cnt;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_6000; bus.cpu_wmask = 4'hF;
        step;
        bus.cpu_req = 1'b0;
        bus.pte_req = 1'b1; bus.pte_we = 1'b0; bus.pte_addr = 32'h8000_3000;
        step;
        bus.pte_addr = 32'h8000_3004;
        @(negedge clk);
        chk("t4_err_before", bus.err, 0);
        step;
        bus.pte_req = 1'b0; bus.dram_ack = 1'b1;
        @(negedge clk);
        chk("t4_err_drop", bus.err, 1);
        chk("t4_cpu_addr", bus.dram_addr, 32'h0000_6000);
        step;
        bus.dram_ack = 1'b0; bus.dram_rvalid = 1'b1; bus.dram_rdata = 32'h1111_2222;
        step;
        bus.dram_rvalid = 1'b0;
        @(negedge clk);
        chk("t4_done_cpu", bus.done_cpu, 1);
        step;
        step;
        bus.dram_ack = 1'b1;
        @(negedge clk);
        chk("t4_pte_addr", bus.dram_addr, 32'h8000_3000);
        step;
        bus.dram_ack = 1'b0; bus.dram_rvalid = 1'b1; bus.dram_rdata = 32'h3333_4444;
        step;
        bus.dram_rvalid = 1'b0;
        @(negedge clk);
        chk("t4_done_pte", bus.done_pte, 1);
        chk("t4_odata", bus.odata, 32'h3333_4444);
        repeat (3) step;
        chk("t4_cmd_total", cmd_cnt - c0, 2);
        chk("t4_busy_end", bus.busy, 0);
        chk("t4_err_sticky", bus.err, 1);

        // Reset clears sticky err
        rst = 1'b1;
        #1;
        chk("t5_rst_err", bus.err, 0);
        step;
        rst = 1'b0;

        // Read timeout in RDWAIT (TIMEOUT = 8)
        run_txn(1'b0, 1'b0, 32'h0000_7000, 32'h0, 4'hF, 32'h5A5A_A5A5, 32'h5A5A_A5A5);
        step;
        bus.pte_req = 1'b1; bus.pte_we = 1'b0; bus.pte_addr = 32'h8000_4000;
        step;
        bus.pte_req = 1'b0; bus.dram_ack = 1'b1;
        step;
        bus.dram_ack = 1'b0;
        repeat (7) step;
        @(negedge clk);
        chk("t5_err_last_wait", bus.err, 0);
        chk("t5_busy_last_wait", bus.busy, 1);
        chk("t5_done_last_wait", bus.done_pte, 0);
        step;
        @(negedge clk);
        chk("t5_err", bus.err, 1);
        chk("t5_done_pte", bus.done_pte, 1);
        chk("t5_busy", bus.busy, 0);
        chk("t5_odata", bus.odata, 32'h5A5A_A5A5);
        step;
        bus.dram_rvalid = 1'b1; bus.dram_rdata = 32'hBAD0_BAD0;
        step;
        bus.dram_rvalid = 1'b0;
        @(negedge clk);
        chk("t5_late_rvalid", bus.odata, 32'h5A5A_A5A5);
        chk("t5_done_clear", bus.done_pte, 0);

        // Asynchronous reset while in RDWAIT
        step;
        bus.pte_req = 1'b1; bus.pte_we = 1'b0; bus.pte_addr = 32'h8000_5000;
        step;
        bus.pte_req = 1'b0; bus.dram_ack = 1'b1;
        step;
        bus.dram_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_odata", bus.odata, 0);
        chk("t6_rst_err", bus.err, 0);
        chk("t6_rst_req", bus.dram_req, 0);
        chk("t6_rst_addr", bus.dram_addr, 0);
        step;
        rst = 1'b0;
        bus.dram_rvalid = 1'b1; bus.dram_rdata = 32'h7777_8888;
        step;
        bus.dram_rvalid = 1'b0;
        @(negedge clk);
        chk("t6_odata_after", bus.odata, 0);
        chk("t6_busy_after", bus.busy, 0);
        chk("t6_done_after", {bus.done_pte, bus.done_cpu}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
